// File: rtl/cpld_uart_emu.sv
// Device-side stand-in for the CPLD serial controller: host strobes on one side, 8N1 txd/rxd on the other.
// Latency: write commit to start bit 2 cycles; rxd start edge to uart_dataready 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles.
// Backpressure: uart_tbre=0 means writes are dropped; a byte received while the holding register is full is dropped and flagged.
module cpld_uart_emu #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_overrun
);

  // Bit-period counter width; counters run CLKS_PER_BIT-1 down to 0.
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Host strobe tracking
  logic       rdn_q;
  logic       wrn_q;
  logic [7:0] wr_dat;
  logic       wr_commit;
  logic       rd_done;

  // Transmit side
  tx_state_t       tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_idx;
  logic [7:0]      tx_buf;
  logic [7:0]      tx_shift;

  // Receive side
  logic            rxd_s1;
  logic            rxd_s2;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_idx;
  logic [7:0]      rx_shift;
  logic [7:0]      rx_hold;

  // A strobe "completes" on its rising edge: low last cycle, high now.
  assign wr_commit = uart_wrn & ~rdn_unused_guard(wrn_q);
  assign rd_done   = uart_rdn & ~rdn_q;

  // Identity helper keeps the edge expressions symmetric and readable.
  function automatic logic rdn_unused_guard(input logic v);
    return v;
  endfunction

  // Register strobes for edge detection and capture write data while the write strobe is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_q  <= 1'b1;
      wrn_q  <= 1'b1;
      wr_dat <= 8'h00;
    end else begin
      rdn_q <= uart_rdn;
      wrn_q <= uart_wrn;
      if (!uart_wrn) begin
        wr_dat <= data_i;
      end
    end
  end

  // Transmit buffer plus TX FSM; uart_tbre doubles as the "buffer empty" flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_buf    <= 8'h00;
      tx_shift  <= 8'h00;
      txd       <= 1'b1;
      uart_tbre <= 1'b1;
      uart_tsre <= 1'b1;
    end else begin
      // Writes land only in an empty buffer; the FSM only drains a full one,
      // so these two never touch uart_tbre in the same cycle.
      if (wr_commit && uart_tbre) begin
        tx_buf    <= wr_dat;
        uart_tbre <= 1'b0;
      end

      case (tx_state)
        TX_IDLE: begin
          if (!uart_tbre) begin
            tx_shift  <= tx_buf;
            uart_tbre <= 1'b1;
            uart_tsre <= 1'b0;
            txd       <= 1'b0;
            tx_cnt    <= BIT_LAST;
            tx_idx    <= '0;
            tx_state  <= TX_START;
          end
        end

        TX_START: begin
          if (tx_cnt == '0) begin
            txd      <= tx_shift[0];
            tx_idx   <= '0;
            tx_cnt   <= BIT_LAST;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end

        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_idx == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_idx <= tx_idx + 3'd1;
              txd    <= tx_shift[tx_idx + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end

        TX_STOP: begin
          if (tx_cnt == '0) begin
            if (!uart_tbre) begin
              // Next byte already waiting: chain straight into its start bit.
              tx_shift  <= tx_buf;
              uart_tbre <= 1'b1;
              txd       <= 1'b0;
              tx_cnt    <= BIT_LAST;
              tx_idx    <= '0;
              tx_state  <= TX_START;
            end else begin
              uart_tsre <= 1'b1;
              tx_state  <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end

        default: begin
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous serial input (idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
    end
  end

  // RX FSM with mid-bit sampling, holding register, dataready and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state       <= RX_IDLE;
      rx_cnt         <= '0;
      rx_idx         <= '0;
      rx_shift       <= 8'h00;
      rx_hold        <= 8'h00;
      uart_dataready <= 1'b0;
      rx_overrun     <= 1'b0;
    end else begin
      // A completed host read empties the holding register; a byte finishing
      // in the same cycle overrides this below and keeps dataready high.
      if (rd_done) begin
        uart_dataready <= 1'b0;
      end

      case (rx_state)
        RX_IDLE: begin
          if (!rxd_s2) begin
            rx_cnt   <= HALF_LAST;
            rx_idx   <= '0;
            rx_state <= RX_START;
          end
        end

        RX_START: begin
          if (rx_cnt == '0) begin
            if (!rxd_s2) begin
              rx_cnt   <= BIT_LAST;
              rx_idx   <= '0;
              rx_state <= RX_DATA;
            end else begin
              // Line went back high by mid start bit: treat as noise.
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end

        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift[rx_idx] <= rxd_s2;
            rx_cnt           <= BIT_LAST;
            if (rx_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end

        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= RX_IDLE;
            // A low stop bit is a framing error and the byte is simply dropped.
            if (rxd_s2) begin
              if (!uart_dataready || rd_done) begin
                rx_hold        <= rx_shift;
                uart_dataready <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end

        default: begin
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Bus drive follows the read strobe one cycle later; data is zero when not driving.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_oe <= 1'b0;
      data_o  <= 8'h00;
    end else begin
      data_oe <= ~uart_rdn;
      data_o  <= uart_rdn ? 8'h00 : rx_hold;
    end
  end

endmodule
